// File: rtl/debug_dump_sequencer.sv
// Walks PC, register bank and data memory in that order and streams every word MSB-first
// as four UART TX bytes. Optional trailing XOR checksum byte: define DEBUG_DUMP_CHECKSUM_EN.
module debug_dump_sequencer #(
    parameter int NB_DATA    = 32,
    parameter int N_BITS     = 8,
    parameter int NB_PC      = 32,
    parameter int NB_BR_ADDR = 5,
    parameter int BR_WORDS   = 32,
    parameter int NB_DM_ADDR = 5,
    parameter int DM_WORDS   = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [2:0]            i_sel,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic [NB_PC-1:0]      i_pc_value,
    output logic [NB_BR_ADDR-1:0] o_br_addr,
    output logic                  o_br_read,
    input  logic [NB_DATA-1:0]    i_br_data,
    output logic [NB_DM_ADDR-1:0] o_dm_addr,
    output logic                  o_dm_read_enable,
    input  logic [NB_DATA-1:0]    i_dm_data,
    output logic [N_BITS-1:0]     o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done
);

    localparam int NB_IDX = (NB_BR_ADDR > NB_DM_ADDR) ? NB_BR_ADDR : NB_DM_ADDR;
    localparam logic [NB_IDX-1:0] BR_LAST = NB_IDX'(BR_WORDS - 1);
    localparam logic [NB_IDX-1:0] DM_LAST = NB_IDX'(DM_WORDS - 1);
    localparam logic [NB_IDX-1:0] IDX_ONE = NB_IDX'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_NEXT    = 3'd5,
        ST_CKSUM   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC = 2'd0,
        SEC_BR = 2'd1,
        SEC_DM = 2'd2
    } sec_t;

    state_t              r_state;
    state_t              w_state_next;
    sec_t                r_sec;
    sec_t                w_sec_next;
    logic [NB_IDX-1:0]   r_idx;
    logic [NB_IDX-1:0]   w_idx_next;
    logic [1:0]          r_sel_hi;
    logic [NB_DATA-1:0]  r_shift;
    logic [NB_DATA-1:0]  w_pc_ext;
    logic [1:0]          r_bcnt;
    logic [NB_BR_ADDR-1:0] r_br_addr;
    logic [NB_DM_ADDR-1:0] r_dm_addr;
    logic                w_sec_last;
    logic                w_last_byte;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [N_BITS-1:0]   r_cksum;
    logic                r_cksum_phase;
`endif

    generate
        if (NB_PC >= NB_DATA) begin : g_pc_trunc
            assign w_pc_ext = i_pc_value[NB_DATA-1:0];
        end else begin : g_pc_zext
            assign w_pc_ext = {{(NB_DATA-NB_PC){1'b0}}, i_pc_value};
        end
    endgenerate

    always_comb begin
        w_sec_last = 1'b1;
        case (r_sec)
            SEC_PC:  w_sec_last = 1'b1;
            SEC_BR:  w_sec_last = (r_idx == BR_LAST);
            SEC_DM:  w_sec_last = (r_idx == DM_LAST);
            default: w_sec_last = 1'b1;
        endcase
    end

    assign w_last_byte = (r_bcnt == 2'd3);

    always_comb begin
        w_state_next = r_state;
        w_sec_next   = r_sec;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_idx_next = '0;
                    if (i_sel[0]) begin
                        w_sec_next   = SEC_PC;
                        w_state_next = ST_FETCH;
                    end else if (i_sel[1]) begin
                        w_sec_next   = SEC_BR;
                        w_state_next = ST_FETCH;
                    end else if (i_sel[2]) begin
                        w_sec_next   = SEC_DM;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_FETCH: w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = ST_SEND;
            ST_SEND:  w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (w_last_byte) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        w_state_next = r_cksum_phase ? ST_DONE : ST_NEXT;
`else
                        w_state_next = ST_NEXT;
`endif
                    end else begin
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_NEXT: begin
                if (!w_sec_last) begin
                    w_idx_next   = r_idx + IDX_ONE;
                    w_state_next = ST_FETCH;
                end else begin
                    // Index parks at 0 on a section change, so it never runs past a section end.
                    w_idx_next = '0;
                    if (r_sec == SEC_PC && r_sel_hi[0]) begin
                        w_sec_next   = SEC_BR;
                        w_state_next = ST_FETCH;
                    end else if (r_sec != SEC_DM && r_sel_hi[1]) begin
                        w_sec_next   = SEC_DM;
                        w_state_next = ST_FETCH;
                    end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        w_state_next = ST_CKSUM;
`else
                        w_state_next = ST_DONE;
`endif
                    end
                end
            end
            ST_CKSUM: w_state_next = ST_SEND;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_sec     <= SEC_PC;
            r_idx     <= '0;
            r_sel_hi  <= '0;
            r_shift   <= '0;
            r_bcnt    <= '0;
            r_br_addr <= '0;
            r_dm_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_sec   <= w_sec_next;
            r_idx   <= w_idx_next;

            // Only BR/DM enables matter after the first section has been chosen.
            if (r_state == ST_IDLE && i_start) begin
                r_sel_hi <= i_sel[2:1];
            end

            if (r_state == ST_LATCH) begin
                case (r_sec)
                    SEC_PC:  r_shift <= w_pc_ext;
                    SEC_BR:  r_shift <= i_br_data;
                    default: r_shift <= i_dm_data;
                endcase
                r_bcnt <= '0;
            end else if (r_state == ST_WAIT_TX && i_tx_done && !w_last_byte) begin
                r_shift <= r_shift << N_BITS;
                r_bcnt  <= r_bcnt + 2'd1;
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            else if (r_state == ST_CKSUM) begin
                // Count already at 3 so the checksum goes out as a single byte.
                r_shift <= {r_cksum, {(NB_DATA-N_BITS){1'b0}}};
                r_bcnt  <= 2'd3;
            end
`endif

            // Addresses are loaded on the edge entering FETCH so they are stable for the read.
            if (w_state_next == ST_IDLE) begin
                r_br_addr <= '0;
                r_dm_addr <= '0;
            end else if (w_state_next == ST_FETCH) begin
                if (w_sec_next == SEC_BR) begin
                    r_br_addr <= w_idx_next[NB_BR_ADDR-1:0];
                end
                if (w_sec_next == SEC_DM) begin
                    r_dm_addr <= w_idx_next[NB_DM_ADDR-1:0];
                end
            end
        end
    end

`ifdef DEBUG_DUMP_CHECKSUM_EN
    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_cksum       <= '0;
            r_cksum_phase <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_cksum       <= '0;
            r_cksum_phase <= 1'b0;
        end else if (r_state == ST_SEND && !r_cksum_phase) begin
            r_cksum <= r_cksum ^ r_shift[NB_DATA-1 -: N_BITS];
        end else if (r_state == ST_CKSUM) begin
            r_cksum_phase <= 1'b1;
        end
    end
`endif

    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = (r_state == ST_DONE);
    assign o_tx_start       = (r_state == ST_SEND);
    assign o_tx_data        = r_shift[NB_DATA-1 -: N_BITS];
    assign o_br_read        = (r_state == ST_FETCH || r_state == ST_LATCH) && (r_sec == SEC_BR);
    assign o_dm_read_enable = (r_state == ST_FETCH || r_state == ST_LATCH) && (r_sec == SEC_DM);
    assign o_br_addr        = r_br_addr;
    assign o_dm_addr        = r_dm_addr;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer: a reference model lists the expected byte and
// address streams per dump; a monitor compares them as the DUT emits them.
module tb_debug_dump_sequencer;

    localparam int NB_DATA    = 32;
    localparam int N_BITS     = 8;
    localparam int NB_PC      = 32;
    localparam int NB_BR_ADDR = 5;
    localparam int BR_WORDS   = 32;
    localparam int NB_DM_ADDR = 5;
    localparam int DM_WORDS   = 32;

    logic                  i_clock = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_start = 1'b0;
    logic [2:0]            i_sel = 3'b000;
    logic                  o_busy;
    logic                  o_done;
    logic [NB_PC-1:0]      i_pc_value = '0;
    logic [NB_BR_ADDR-1:0] o_br_addr;
    logic                  o_br_read;
    logic [NB_DATA-1:0]    i_br_data = '0;
    logic [NB_DM_ADDR-1:0] o_dm_addr;
    logic                  o_dm_read_enable;
    logic [NB_DATA-1:0]    i_dm_data = '0;
    logic [N_BITS-1:0]     o_tx_data;
    logic                  o_tx_start;
    logic                  i_tx_done;

    logic tx_done_model  = 1'b0;
    logic tx_done_inject = 1'b0;
    assign i_tx_done = tx_done_model | tx_done_inject;

    debug_dump_sequencer #(
        .NB_DATA(NB_DATA), .N_BITS(N_BITS), .NB_PC(NB_PC),
        .NB_BR_ADDR(NB_BR_ADDR), .BR_WORDS(BR_WORDS),
        .NB_DM_ADDR(NB_DM_ADDR), .DM_WORDS(DM_WORDS)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_sel(i_sel),
        .o_busy(o_busy), .o_done(o_done), .i_pc_value(i_pc_value),
        .o_br_addr(o_br_addr), .o_br_read(o_br_read), .i_br_data(i_br_data),
        .o_dm_addr(o_dm_addr), .o_dm_read_enable(o_dm_read_enable), .i_dm_data(i_dm_data),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done)
    );

    always #5 i_clock = ~i_clock;

    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;
    int tx_delay_min = 1;
    int tx_delay_max = 4;

    logic [31:0] br_mem [BR_WORDS];
    logic [31:0] dm_mem [DM_WORDS];
    logic [7:0]  exp_q [$];
    logic [4:0]  br_addr_q [$];
    logic [4:0]  dm_addr_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Memories answer one falling edge after address and enable.
    always @(negedge i_clock) begin
        if (o_br_read) i_br_data <= br_mem[o_br_addr];
        if (o_dm_read_enable) i_dm_data <= dm_mem[o_dm_addr];
    end

    // UART model: i_tx_done pulses for one cycle a random number of cycles after each start.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge i_clock);
            tx_done_model = 1'b0;
            if (i_reset) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done_model = 1'b1;
            end
            if (o_tx_start && !i_reset) cnt = $urandom_range(tx_delay_max, tx_delay_min);
        end
    end

    // Monitor
    logic prev_tx_start = 1'b0, prev_br = 1'b0, prev_dm = 1'b0, prev_done = 1'b0;
    always @(posedge i_clock) begin
        if (mon_en) begin
            if (i_reset) begin
                exp_q.delete();
                br_addr_q.delete();
                dm_addr_q.delete();
            end else begin
                if (!o_busy)
                    check("idle_outputs",
                          {o_tx_start, o_br_read, o_dm_read_enable, o_br_addr, o_dm_addr}, 0);
                if (o_tx_start) begin
                    check("busy_during_tx", o_busy, 1);
                    if (prev_tx_start) fail("tx_start_two_cycles");
                    if (exp_q.size() == 0) fail("tx_byte_unexpected");
                    else check("tx_byte", o_tx_data, exp_q.pop_front());
                end
                if (o_br_read && !prev_br) begin
                    if (br_addr_q.size() == 0) fail("br_read_unexpected");
                    else check("br_addr", o_br_addr, br_addr_q.pop_front());
                end
                if (o_dm_read_enable && !prev_dm) begin
                    if (dm_addr_q.size() == 0) fail("dm_read_unexpected");
                    else check("dm_addr", o_dm_addr, dm_addr_q.pop_front());
                end
                if (o_done) begin
                    if (prev_done) fail("done_two_cycles");
                    check("bytes_left_at_done", exp_q.size(), 0);
                    check("br_reads_left_at_done", br_addr_q.size(), 0);
                    check("dm_reads_left_at_done", dm_addr_q.size(), 0);
                    done_seen <= done_seen + 1;
                end
            end
        end
        prev_tx_start <= o_tx_start;
        prev_br       <= o_br_read;
        prev_dm       <= o_dm_read_enable;
        prev_done     <= o_done;
    end

    task automatic push_word(input logic [31:0] w, inout logic [7:0] ck);
        for (int b = 3; b >= 0; b--) begin
            logic [7:0] by;
            by = w[8*b +: 8];
            exp_q.push_back(by);
            ck ^= by;
        end
    endtask

    // Reference model: sections in order PC, BR, DM; each word MSB-first.
    task automatic expect_dump(input logic [2:0] sel, input logic [31:0] pc);
        logic [7:0] ck;
        ck = 8'h00;
        if (sel[0]) push_word(pc, ck);
        if (sel[1]) begin
            for (int n = 0; n < BR_WORDS; n++) begin
                push_word(br_mem[n], ck);
                br_addr_q.push_back(5'(n));
            end
        end
        if (sel[2]) begin
            for (int n = 0; n < DM_WORDS; n++) begin
                push_word(dm_mem[n], ck);
                dm_addr_q.push_back(5'(n));
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (sel != 3'b000) exp_q.push_back(ck);
`endif
    endtask

    task automatic run_dump(input logic [2:0] sel, input logic [31:0] pc,
                            input int dmin, input int dmax, input bit inject);
        int lat;
        int start_cnt;
        int cyc;
        bit prev_en;
        bit inj_armed;
        tx_delay_min = dmin;
        tx_delay_max = dmax;
        i_pc_value   = pc;
        expect_dump(sel, pc);
        start_cnt = done_seen;
        @(posedge i_clock);
        i_start = 1'b1;
        i_sel   = sel;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge i_clock);
            if (k == 1) begin
                i_start = 1'b0;
                i_sel   = 3'($urandom);
            end
            if (o_tx_start || o_done) begin
                lat = k;
                break;
            end
        end
        check("start_latency", lat, (sel == 3'b000) ? 1 : 3);
        cyc = 0;
        prev_en = 1'b1;
        inj_armed = inject;
        while (done_seen == start_cnt && cyc < 20000) begin
            @(posedge i_clock);
            cyc++;
            tx_done_inject = 1'b0;
            i_start = 1'b0;
            if (inject && cyc == 4) begin
                i_start = 1'b1;
                i_sel   = 3'b111;
            end
            if (inj_armed && cyc > 4 && o_dm_read_enable && !prev_en) begin
                tx_done_inject = 1'b1;
                inj_armed = 1'b0;
            end
            prev_en = o_dm_read_enable;
        end
        if (cyc >= 20000) fail("done_timeout");
        tx_done_inject = 1'b0;
        i_start = 1'b0;
        repeat (2) @(posedge i_clock);
    endtask

    initial begin
        int wait_cyc;
        for (int n = 0; n < BR_WORDS; n++) br_mem[n] = 32'(n);
        for (int n = 0; n < DM_WORDS; n++) dm_mem[n] = 32'hDEAD_0000 + 32'(n);

        repeat (3) @(posedge i_clock);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_tx", {o_tx_start, o_tx_data}, 0);
        check("reset_reads", {o_br_read, o_dm_read_enable}, 0);
        check("reset_addrs", {o_br_addr, o_dm_addr}, 0);
        i_reset = 1'b0;
        mon_en  = 1'b1;
        repeat (2) @(posedge i_clock);

        // PC only, 10-cycle TX: 00 00 0A 1C
        run_dump(3'b001, 32'h0000_0A1C, 10, 10, 1'b0);

        // Reset while waiting on the TX handshake
        tx_delay_min = 10;
        tx_delay_max = 10;
        i_pc_value = 32'h1234_5678;
        expect_dump(3'b001, 32'h1234_5678);
        @(posedge i_clock);
        i_start = 1'b1;
        i_sel   = 3'b001;
        wait_cyc = 0;
        do begin
            @(posedge i_clock);
            i_start = 1'b0;
            wait_cyc++;
        end while (!o_tx_start && wait_cyc < 10);
        if (!o_tx_start) fail("reset_test_no_tx_start");
        @(posedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        check("midreset_busy", o_busy, 0);
        check("midreset_tx_start", o_tx_start, 0);
        @(posedge i_clock);
        i_reset = 1'b0;
        repeat (3) @(posedge i_clock);
        run_dump(3'b001, 32'hCAFE_F00D, 1, 3, 1'b0);

        // Empty mask
        run_dump(3'b000, 32'h0, 1, 2, 1'b0);

        // DM only with ignored start and stray tx_done in FETCH
        run_dump(3'b100, 32'h0, 1, 3, 1'b1);

        // Full dump
        run_dump(3'b111, 32'h0040_0010, 1, 3, 1'b0);

        // Randomized dumps
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < BR_WORDS; n++) br_mem[n] = $urandom;
            for (int n = 0; n < DM_WORDS; n++) dm_mem[n] = $urandom;
            run_dump(3'($urandom_range(7, 0)), $urandom, 1, 4, r[0]);
        end

        check("final_bytes_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
